// File: rtl/ddr3_iod_dly_lane_ctrl_if.sv
// Request/completion bus between the training FSM (master) and the
// delay-line lane sequencer (slave).
interface ddr3_iod_dly_lane_ctrl_if #(
  parameter int LANE_W = 4,
  parameter int TAP_W  = 8
);
  logic              REQ_VALID;
  logic              REQ_READY;
  logic [LANE_W-1:0] REQ_LANE;
  logic [TAP_W-1:0]  REQ_TAP;
  logic              REQ_LOAD;
  logic              DONE_VALID;
  logic [LANE_W-1:0] DONE_LANE;
  logic              DONE_ERR;
  logic [TAP_W-1:0]  DONE_TAP;

  modport master (
    output REQ_VALID, REQ_LANE, REQ_TAP, REQ_LOAD,
    input  REQ_READY, DONE_VALID, DONE_LANE, DONE_ERR, DONE_TAP
  );

  modport slave (
    input  REQ_VALID, REQ_LANE, REQ_TAP, REQ_LOAD,
    output REQ_READY, DONE_VALID, DONE_LANE, DONE_ERR, DONE_TAP
  );
endinterface

// File: rtl/ddr3_iod_dly_lane_ctrl.sv
// Steps one IOD delay line at a time toward a requested tap, keeping a
// shadow tap count per lane and reporting completion or range errors.
module ddr3_iod_dly_lane_ctrl #(
  parameter int NUM_LANES  = 16,
  parameter int LANE_W     = 4,
  parameter int TAP_W      = 8,
  parameter int MAX_TAP    = 127,
  parameter int LOAD_TAP   = 1,
  parameter int SETTLE_CYC = 3
) (
  input  logic                 FAB_CLK,
  input  logic                 TX_SYNC_RST,
  ddr3_iod_dly_lane_ctrl_if.slave bus,
  output logic [NUM_LANES-1:0] DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0] DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0] DELAY_LINE_DIRECTION,
  input  logic [NUM_LANES-1:0] DELAY_LINE_OUT_OF_RANGE,
  input  logic [LANE_W-1:0]    RD_LANE,
  output logic [TAP_W-1:0]     RD_TAP
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LOAD_WAIT, S_CHECK, S_SETUP, S_MOVE, S_SETTLE, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [TAP_W-1:0]     tap_q, tap_d;
  logic                 err_q, err_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [NUM_LANES-1:0] dir_q, dir_d;
  logic [TAP_W-1:0]     shadow_q [NUM_LANES];
  logic [TAP_W-1:0]     shadow_d [NUM_LANES];

  logic                 lane_ok;
  logic [TAP_W-1:0]     cur_tap;

  assign lane_ok = int'(lane_q) < NUM_LANES;
  assign cur_tap = lane_ok ? shadow_q[lane_q] : '0;

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    tap_d    = tap_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    shadow_d = shadow_q;
    case (state_q)
      S_IDLE: begin
        if (bus.REQ_VALID) begin
          lane_d = bus.REQ_LANE;
          tap_d  = bus.REQ_TAP;
          err_d  = 1'b0;
          // Illegal targets never touch the delay line.
          if ((int'(bus.REQ_TAP) > MAX_TAP) || (int'(bus.REQ_LANE) >= NUM_LANES)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (bus.REQ_LOAD) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_CHECK;
          end
        end
      end
      S_LOAD: begin
        shadow_d[lane_q] = TAP_W'(LOAD_TAP);
        cnt_d            = 4'(SETTLE_CYC - 1);
        state_d          = S_LOAD_WAIT;
      end
      S_LOAD_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_CHECK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_CHECK: begin
        if (cur_tap == tap_q) begin
          state_d = S_DONE;
        end else begin
          dir_d[lane_q] = tap_q > cur_tap;
          state_d       = S_SETUP;
        end
      end
      S_SETUP: state_d = S_MOVE;
      S_MOVE: begin
        shadow_d[lane_q] = dir_q[lane_q] ? cur_tap + TAP_W'(1) : cur_tap - TAP_W'(1);
        cnt_d            = 4'(SETTLE_CYC - 1);
        state_d          = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (DELAY_LINE_OUT_OF_RANGE[lane_q]) begin
          // The IOD refused the last step, so undo it in the shadow.
          shadow_d[lane_q] = dir_q[lane_q] ? cur_tap - TAP_W'(1) : cur_tap + TAP_W'(1);
          err_d            = 1'b1;
          state_d          = S_DONE;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      tap_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= '0;
      for (int i = 0; i < NUM_LANES; i++) shadow_q[i] <= TAP_W'(LOAD_TAP);
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      tap_q    <= tap_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      shadow_q <= shadow_d;
    end
  end

  assign bus.REQ_READY      = state_q == S_IDLE;
  assign bus.DONE_VALID     = state_q == S_DONE;
  assign bus.DONE_ERR       = (state_q == S_DONE) && err_q;
  assign bus.DONE_LANE      = (state_q == S_DONE) ? lane_q : '0;
  assign bus.DONE_TAP       = (state_q == S_DONE) ? cur_tap : '0;
  assign DELAY_LINE_LOAD    = (state_q == S_LOAD) ? (NUM_LANES'(1) << lane_q) : '0;
  assign DELAY_LINE_MOVE    = (state_q == S_MOVE) ? (NUM_LANES'(1) << lane_q) : '0;
  assign DELAY_LINE_DIRECTION = dir_q;
  assign RD_TAP             = (int'(RD_LANE) < NUM_LANES) ? shadow_q[RD_LANE] : '0;

endmodule

// File: doc/ddr3_iod_dly_lane_ctrl.md
Name: ddr3_iod_dly_lane_ctrl

Overview:
Parametrised delay-line sequencer for the DDR3 address/command IOD bank. It serves one outstanding "set lane N to tap T" request at a time. For each request it drives the per-lane DELAY_LINE_LOAD, DELAY_LINE_MOVE and DELAY_LINE_DIRECTION strobes one tap at a time and keeps a shadow tap count per lane. It sits between the training/calibration FSM and NUM_LANES IOD wrapper instances, and handles out-of-range aborts and settle time.

Parameters:
NUM_LANES, 16, number of IOD lanes controlled (1..32)
LANE_W, 4, width of lane index; must be >= clog2(NUM_LANES)
TAP_W, 8, width of tap values
MAX_TAP, 127, highest legal target tap
LOAD_TAP, 1, tap value a delay line holds after a LOAD strobe
SETTLE_CYC, 3, idle cycles after each strobe before the next action (1..15)

Ports:
FAB_CLK  in  1  fabric clock; all logic on rising edge
TX_SYNC_RST  in  1  synchronous reset, active-high
REQ_VALID  in  1  request present
REQ_READY  out  1  block can accept a request
REQ_LANE  in  LANE_W  target lane
REQ_TAP  in  TAP_W  target tap
REQ_LOAD  in  1  load the lane to LOAD_TAP before stepping
DONE_VALID  out  1  one-cycle completion pulse
DONE_LANE  out  LANE_W  lane of the completed request
DONE_ERR  out  1  request failed (qualifies DONE_VALID)
DONE_TAP  out  TAP_W  lane shadow tap at completion
DELAY_LINE_LOAD  out  NUM_LANES  per-lane load strobe
DELAY_LINE_MOVE  out  NUM_LANES  per-lane move strobe
DELAY_LINE_DIRECTION  out  NUM_LANES  per-lane direction, 1 = increment
DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  per-lane IOD range flag
RD_LANE  in  LANE_W  readback lane select
RD_TAP  out  TAP_W  combinational readback of shadow tap[RD_LANE]

Behaviour:
Interface: one clock, FAB_CLK. Reset TX_SYNC_RST is synchronous and active-high.

Reset (also when asserted mid-operation):
- State goes to IDLE.
- All strobes, DIRECTION bits, DONE_* and DONE_ERR go to 0. REQ_READY goes to 1.
- Every shadow tap goes to LOAD_TAP.
- An in-flight request is dropped and no DONE pulse is issued.

Request handshake:
- REQ_READY = 1 only in IDLE.
- A request is accepted on the edge where REQ_VALID & REQ_READY. Lane, tap and load are latched on that edge; request inputs are ignored afterwards.

States: IDLE, LOAD, LOAD_WAIT, CHECK, SETUP, MOVE, SETTLE, DONE.
- IDLE -> LOAD if REQ_LOAD, else -> CHECK.
- Range check on entry: REQ_TAP > MAX_TAP or REQ_LANE >= NUM_LANES goes straight to DONE with ERR=1, skipping LOAD.
- LOAD: DELAY_LINE_LOAD[lane]=1 for exactly 1 cycle; shadow[lane] := LOAD_TAP. Then LOAD_WAIT for SETTLE_CYC cycles, then CHECK.
- CHECK: if shadow == target -> DONE with ERR=0, else -> SETUP.
- SETUP: DIRECTION[lane] := (target > shadow). DIRECTION is held stable from SETUP through the end of SETTLE.
- MOVE: DELAY_LINE_MOVE[lane]=1 for exactly 1 cycle; shadow[lane] is incremented or decremented on the same edge.
- SETTLE: lasts SETTLE_CYC cycles.
  - OUT_OF_RANGE[lane] sampled high on the last SETTLE cycle: revert shadow by one step, -> DONE with ERR=1.
  - Otherwise -> CHECK.
- DONE: DONE_VALID=1 for 1 cycle with DONE_LANE, DONE_TAP, DONE_ERR; next state IDLE.

Signal rules:
- Only the addressed lane's strobe bits ever toggle. Other lanes' bits stay 0; their DIRECTION bits hold their last value.
- At most one strobe is high per cycle across the whole block.

Latency (accept on edge k, S = SETTLE_CYC, d = |target - start tap|):
- DONE_VALID is high in cycle k + 2 + d·(3+S).
- REQ_LOAD adds 1+S cycles, with the start tap taken as LOAD_TAP.
- Illegal request: DONE_VALID in cycle k+1.
- Next acceptance is possible at the earliest one cycle after DONE.

Widths: the shadow tap never wraps. Increment and decrement can only happen toward a legal target, so the shadow stays in 0..MAX_TAP.

Readback: RD_TAP reflects the register value, so an update on edge e is visible from cycle e+1.

Test Plan:
1. Reset, then RD_LANE=0..15 -> RD_TAP=1 for every lane; REQ_READY=1; all strobes 0.
2. S=3, lane 5, REQ_TAP=4, no load, accepted at k -> 3 MOVE pulses with DIRECTION[5]=1; DONE_VALID at k+20 with DONE_TAP=4, ERR=0.
3. Lane 5 (at tap 4), REQ_TAP=2, REQ_LOAD=1 -> one LOAD pulse, then a single increment step (1 to 2); DONE at k+2+4+6=k+12 with DONE_TAP=2.
4. REQ_TAP=200 -> no strobes; DONE at k+1 with ERR=1; shadow unchanged.
5. Lane 3, REQ_TAP=10, OUT_OF_RANGE[3] forced high after the 2nd MOVE -> DONE with ERR=1, DONE_TAP=2 (one step reverted); RD_TAP(3)=2.
6. TX_SYNC_RST asserted for 1 cycle mid-SETTLE -> no DONE pulse; all taps read back 1; REQ_READY=1 on the next cycle.
